// File: rtl/trng_conditioner.sv
// Multi-oscillator entropy conditioner: synchronise, divide, XOR-combine, optional
// von Neumann debias, repetition-count health test, and pack into handshaked words.
module trng_conditioner #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       osc_in,
  input  logic                    enable,
  input  logic                    debias,
  input  logic [DIV_W-1:0]        sample_div,
  input  logic                    fault_clr,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    fault,
  output logic [$clog2(WORD_W):0] bit_count
);
  localparam int unsigned CNT_W = $clog2(WORD_W) + 1;
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  div_lim_q, div_lim_d;
  logic [DIV_W-1:0]  lim_eff;
  logic              prev_q, prev_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              fault_q, fault_d;
  logic              vn_have_q, vn_have_d;
  logic              vn_first_q, vn_first_d;
  logic              debias_q;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              x, strobe, emit, bit_b, vn_clr, accept;

  always_comb begin
    x          = ^sync2_q;
    // Period limit is captured at the start of each period, so a new sample_div waits for the wrap
    lim_eff    = (div_cnt_q == '0) ? sample_div : div_lim_q;
    strobe     = enable && (div_cnt_q == lim_eff);
    div_cnt_d  = div_cnt_q;
    div_lim_d  = div_lim_q;
    prev_d     = prev_q;
    rep_d      = rep_q;
    fault_d    = fault_q;
    vn_have_d  = vn_have_q;
    vn_first_d = vn_first_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    bit_b      = x;
    vn_clr     = fault_clr || (debias != debias_q) || !debias;
    accept     = 1'b0;

    if (enable) begin
      div_lim_d = lim_eff;
      div_cnt_d = strobe ? '0 : DIV_W'(div_cnt_q + DIV_W'(1));
    end

    // Repetition count restarts at 1 on a new value; count of 0 means no history
    if (strobe) begin
      prev_d = x;
      if ((rep_q == '0) || (x != prev_q)) begin
        rep_d = REP_W'(1);
      end else if (rep_q != REP_W'(REP_LIMIT)) begin
        rep_d = REP_W'(rep_q + REP_W'(1));
      end
    end
    if (fault_clr) begin
      rep_d   = '0;
      fault_d = 1'b0;
    end else if (strobe && (rep_d == REP_W'(REP_LIMIT))) begin
      fault_d = 1'b1;
    end

    if (!debias) begin
      emit = strobe;
    end else if (!vn_clr && strobe) begin
      if (!vn_have_q) begin
        vn_have_d  = 1'b1;
        vn_first_d = x;
      end else begin
        vn_have_d = 1'b0;
        emit      = vn_first_q ^ x;
        bit_b     = vn_first_q;
      end
    end
    if (vn_clr) begin
      vn_have_d = 1'b0;
    end

    // Bits are dropped while faulted or while a finished word waits without a handshake
    accept = emit && !fault_q && (!valid_q || out_ready);
    if (accept) begin
      data_d = {data_q[WORD_W-2:0], bit_b};
      if (cnt_q == CNT_W'(WORD_W - 1)) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
        valid_d = 1'b0;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      div_cnt_q  <= '0;
      div_lim_q  <= '0;
      prev_q     <= 1'b0;
      rep_q      <= '0;
      fault_q    <= 1'b0;
      vn_have_q  <= 1'b0;
      vn_first_q <= 1'b0;
      debias_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= osc_in;
      sync2_q    <= sync1_q;
      div_cnt_q  <= div_cnt_d;
      div_lim_q  <= div_lim_d;
      prev_q     <= prev_d;
      rep_q      <= rep_d;
      fault_q    <= fault_d;
      vn_have_q  <= vn_have_d;
      vn_first_q <= vn_first_d;
      debias_q   <= debias;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign fault     = fault_q;
  assign bit_count = cnt_q;

endmodule
